// File: rtl/mod_cntr_if.sv
// Control and status bundle for mod_cntr: step/load controls in, count and flags out.
interface mod_cntr_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] max_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up, load, load_val, max_val, clr_ovf,
    input  count, tc, ovf
  );

  modport slave (
    input  en, up, load, load_val, max_val, clr_ovf,
    output count, tc, ovf
  );
endinterface

// File: rtl/mod_cntr.sv
// Registered modulo up/down counter with lower bound 0 and programmable upper bound,
// wrap or saturate at the bounds, terminal-count pulse and sticky overflow flag.
module mod_cntr #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input logic         clk,
  input logic         rst,
  mod_cntr_if.slave   bus
);
  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic             ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      // A boundary event later in this block overrides the clear.
      if (bus.clr_ovf) ovf_q <= 1'b0;
      if (bus.load) begin
        count_q <= (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
      end else if (bus.en) begin
        if (bus.up) begin
          if (count_q >= bus.max_val) begin
            count_q <= SATURATE ? bus.max_val : '0;
            tc_q    <= 1'b1;
            ovf_q   <= 1'b1;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end else begin
          // Above the bound after a max_val change: pull back silently.
          if (count_q > bus.max_val) begin
            count_q <= bus.max_val;
          end else if (count_q == '0) begin
            count_q <= SATURATE ? '0 : bus.max_val;
            tc_q    <= 1'b1;
            ovf_q   <= 1'b1;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
      end
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;
endmodule
